// File: rtl/instr_mem_loader_pkg.sv
// Shared constants and state encoding for the instruction memory loader.
package instr_mem_loader_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_W     = 8 * WORD_BYTES;
    localparam int unsigned LANE_W     = $clog2(WORD_BYTES);

    typedef enum logic [1:0] {
        S_LEN  = 2'd0,
        S_DATA = 2'd1,
        S_CSUM = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-memory write/status bundle of the loader.
interface instr_mem_loader_if;

    logic        i_rx_valid;
    logic [7:0]  i_rx_data;
    logic        o_rx_ready;
    logic        o_we;
    logic [31:0] o_wadr;
    logic [31:0] o_wdata;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic        o_cpu_rst;
    logic [31:0] o_word_cnt;

    modport master (
        output i_rx_valid, i_rx_data,
        input  o_rx_ready, o_we, o_wadr, o_wdata, o_busy, o_done, o_err,
               o_cpu_rst, o_word_cnt
    );

    modport slave (
        input  i_rx_valid, i_rx_data,
        output o_rx_ready, o_we, o_wadr, o_wdata, o_busy, o_done, o_err,
               o_cpu_rst, o_word_cnt
    );

endinterface

// File: rtl/instr_mem_loader_assembler.sv
// le_word_assembler: packs accepted bytes into little-endian 32-bit words.
// o_word_c already includes the byte being accepted, so a word is available
// combinationally in the cycle its last byte transfers.
module le_word_assembler
    import instr_mem_loader_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [7:0]        i_data,
    output logic              o_word_valid_c,
    output logic [WORD_W-1:0] o_word_c
);

    logic [LANE_W-1:0] lane;
    logic [WORD_W-1:0] shreg;

    // Merge the incoming byte into its lane of the partial word.
    always_comb begin
        o_word_c = shreg;
        o_word_c[8*lane +: 8] = i_data;
    end

    assign o_word_valid_c = i_en && (lane == LANE_W'(WORD_BYTES - 1));

    // Lane counter wraps 3->0; partial word clears once a word completes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lane  <= '0;
            shreg <= '0;
        end else if (i_en) begin
            lane  <= lane + LANE_W'(1);
            shreg <= o_word_valid_c ? '0 : o_word_c;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: boot-time writer for the instruction memory.
// Frame: 32-bit LE word count N, then N LE words. Holds the core in reset
// until the frame completes. Optional trailing XOR checksum byte when
// LOADER_CHECKSUM_EN is defined.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 20,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1 << (ADDR_W - 2)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    instr_mem_loader_if.slave  bus
);

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_END = S_CSUM;
`else
    localparam state_t S_END = S_DONE;
`endif

    state_t            state;
    logic [31:0]       n_words;
    logic [31:0]       rcv_cnt;
    logic              take_c;
    logic              asm_en_c;
    logic              word_valid_c;
    logic [WORD_W-1:0] word_c;
    logic              last_word_c;
    logic              enter_done_c;

    assign take_c      = bus.i_rx_valid && bus.o_rx_ready;
    assign asm_en_c    = take_c && ((state == S_LEN) || (state == S_DATA));
    assign last_word_c = (rcv_cnt + 32'd1) == n_words;

    le_word_assembler u_asm (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_en           (asm_en_c),
        .i_data         (bus.i_rx_data),
        .o_word_valid_c (word_valid_c),
        .o_word_c       (word_c)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;

    // Running XOR over every length and data byte of the frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            csum <= '0;
        end else if (asm_en_c) begin
            csum <= csum ^ bus.i_rx_data;
        end
    end

    assign enter_done_c = (state == S_CSUM) && take_c;
`else
    assign enter_done_c = word_valid_c &&
                          (((state == S_LEN) && (word_c == '0)) ||
                           ((state == S_DATA) && last_word_c));
`endif

    // Frame FSM with write generation, overflow/checksum errors and status.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= S_LEN;
            n_words        <= '0;
            rcv_cnt        <= '0;
            bus.o_we       <= 1'b0;
            bus.o_wadr     <= '0;
            bus.o_wdata    <= '0;
            bus.o_done     <= 1'b0;
            bus.o_err      <= 1'b0;
            bus.o_word_cnt <= '0;
            bus.o_busy     <= 1'b1;
            bus.o_cpu_rst  <= 1'b1;
            bus.o_rx_ready <= 1'b1;
        end else begin
            bus.o_we <= 1'b0;
            case (state)
                S_LEN: begin
                    if (word_valid_c) begin
                        n_words <= word_c;
                        state   <= (word_c == '0) ? S_END : S_DATA;
                    end
                end
                S_DATA: begin
                    if (word_valid_c) begin
                        if (rcv_cnt < 32'(MAX_WORDS)) begin
                            bus.o_we       <= 1'b1;
                            bus.o_wadr     <= BASE_ADDR + {bus.o_word_cnt[29:0], 2'b00};
                            bus.o_wdata    <= word_c;
                            bus.o_word_cnt <= bus.o_word_cnt + 32'd1;
                        end else begin
                            bus.o_err <= 1'b1;
                        end
                        rcv_cnt <= rcv_cnt + 32'd1;
                        if (last_word_c) begin
                            state <= S_END;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (take_c) begin
                        if (bus.i_rx_data != csum) begin
                            bus.o_err <= 1'b1;
                        end
                        state <= S_DONE;
                    end
                end
`endif
                default: ;
            endcase
            if (enter_done_c) begin
                bus.o_done     <= 1'b1;
                bus.o_busy     <= 1'b0;
                bus.o_cpu_rst  <= 1'b0;
                bus.o_rx_ready <= 1'b0;
            end
        end
    end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Boot-time writer for the byte-addressable, little-endian instruction memory, which the core otherwise only reads.
- Accepts a byte stream on a valid/ready interface, e.g. from a UART receiver.
- Assembles 32-bit little-endian words and issues single-cycle word writes to the instruction memory write port.
- Holds the core in reset until the image is fully loaded.

Parameters:
ADDR_W, 20, byte-address width of the instruction memory (capacity 2^ADDR_W bytes)
BASE_ADDR, 32'h0000_0000, byte address of the first loaded word; must be 4-byte aligned
MAX_WORDS, 1<<(ADDR_W-2), maximum number of words accepted for writing

Ports:
i_clk  in  1  clock; all state updates on the rising edge
i_rst  in  1  asynchronous, active-high reset
i_rx_valid  in  1  input byte valid
i_rx_data  in  8  input byte
o_rx_ready  out  1  loader can accept a byte; a byte transfers when i_rx_valid && o_rx_ready at the clock edge
o_we  out  1  one-cycle word write strobe to the instruction memory
o_wadr  out  32  byte address of the write: BASE_ADDR + 4*word_index
o_wdata  out  32  write word; byte 0 received goes to [7:0], byte 3 goes to [31:24]
o_busy  out  1  load in progress
o_done  out  1  image complete; sticky until reset
o_err  out  1  overflow or checksum error; sticky until reset
o_cpu_rst  out  1  core reset; high from reset until o_done rises
o_word_cnt  out  32  number of words written so far

Behaviour:
- Frame format: 4-byte little-endian word count N, then N words of 4 bytes each, little-endian.
- States: S_LEN, S_DATA, S_CSUM (feature only), S_DONE.
- Reset (async, immediate):
  - state=S_LEN; byte index=0; word count, N and shift register all 0.
  - o_we=0, o_wadr=0, o_wdata=0, o_done=0, o_err=0, o_word_cnt=0.
  - o_busy=1, o_cpu_rst=1, o_rx_ready=1.
- o_rx_ready=1 in S_LEN, S_DATA and S_CSUM; 0 in S_DONE. It is decoded from the registered state.
- S_LEN: each accepted byte is shifted into N at position 8*byte_index. On the 4th byte:
  - N==0: go to S_CSUM if the feature is enabled, else S_DONE.
  - otherwise: go to S_DATA.
- S_DATA: each accepted byte is placed into word byte lane byte_index. Byte_index wraps 3->0.
- Word write: the cycle after the 4th byte of a word is accepted, o_we=1 for exactly one cycle.
  - o_wdata = assembled word; o_wadr = BASE_ADDR + 4*o_word_cnt (pre-increment value).
  - o_word_cnt increments in the same cycle.
  - Write latency from the last byte accepted to o_we is exactly 1 cycle.
  - Back-to-back bytes are legal; the next word's byte 0 may be accepted in the same cycle o_we is high.
- Overflow: a word whose index >= MAX_WORDS is not written (o_we stays 0) and does not increment o_word_cnt. o_err is set and its bytes are still consumed.
- After the last word (received word count == N): go to S_CSUM or S_DONE.
- S_DONE:
  - o_done=1, o_busy=0.
  - o_cpu_rst drops to 0 in the same cycle o_done rises, i.e. the first cycle in S_DONE.
  - Any further bytes are refused.
- The transition into S_DONE is registered. The final o_we pulse and the S_DONE entry coincide in the same cycle; the last write is therefore visible to memory before the core leaves reset.
- Byte gaps (i_rx_valid=0): the FSM holds and nothing changes.
- Reset mid-load: everything returns to reset values and the partially written memory is left as is. A new frame starts at S_LEN.
- N is 32-bit; the received word counter compares against the full 32-bit N.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined:
  - After the last data word (or after the length field when N==0), S_CSUM accepts one byte.
  - That byte must equal the XOR of all preceding frame bytes, including the 4 length bytes.
  - Mismatch sets o_err. Done is still asserted.
- Undefined: S_CSUM is absent and the frame ends after the data words.

Decomposition:
- Shared package: state encoding constants (S_LEN, S_DATA, S_CSUM, S_DONE) and WORD_BYTES=4.
- One natural sub-module, le_word_assembler: byte lane counter plus shift register, emitting a word_valid pulse and the assembled word.
- The FSM, address generation and error logic stay in instr_mem_loader.

Test Plan:
1. Stream 01 00 00 00, EF BE AD DE with no gaps -> exactly one o_we pulse 1 cycle after the last byte, o_wadr=0x0, o_wdata=0xDEADBEEF. o_done=1 and o_cpu_rst=0 in the same cycle as o_we; o_word_cnt=1.
2. N=3 with random i_rx_valid gaps -> o_we pulses at o_wadr=0x0, 0x4, 0x8 with little-endian data. o_rx_ready=0 after done; extra bytes are ignored.
3. N=0 -> no o_we; o_done=1 one cycle after the 4th length byte (feature off).
4. MAX_WORDS=2, N=3 -> two writes only, o_err=1, o_word_cnt=2, o_done=1.
5. Assert i_rst after 2 of 3 words -> all outputs return to reset values immediately. A fresh frame with N=1 writes to o_wadr=BASE_ADDR.
6. LOADER_CHECKSUM_EN, frame 01 00 00 00 11 22 33 44 plus checksum byte 0x45 -> o_done=1, o_err=0. The same frame with checksum 0x00 -> o_done=1, o_err=1.
